// File: rtl/alu_pkg.sv
// Shared constants for the registered EX-stage ALU with iterative multiply/divide.
package alu_pkg;
    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0001;
    localparam logic [3:0] FN_OR    = 4'b0010;
    localparam logic [3:0] FN_AND   = 4'b0011;
    localparam logic [3:0] FN_XOR   = 4'b0100;
    localparam logic [3:0] FN_XNOR  = 4'b0101;
    localparam logic [3:0] FN_SLT   = 4'b0110;
    localparam logic [3:0] FN_LUI   = 4'b0111;
    localparam logic [3:0] FN_MULT  = 4'b1000;
    localparam logic [3:0] FN_MULTU = 4'b1001;
    localparam logic [3:0] FN_DIV   = 4'b1010;
    localparam logic [3:0] FN_DIVU  = 4'b1011;
    localparam logic [3:0] FN_MFHI  = 4'b1100;
    localparam logic [3:0] FN_MFLO  = 4'b1101;
    localparam logic [3:0] FN_SLTU  = 4'b1110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
endpackage

// File: rtl/alu_md_iter.sv
// Radix-2 iterative multiply / restoring divide on operand magnitudes, signs applied in FIX.
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, sh, opd;
    logic             div_mode, neg_p, neg_r, dz;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_rsh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo, rem;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // mult: acc:sh is the running product, sh starts as the multiplier
    // div:  acc is the partial remainder, sh shifts dividend out and quotient in
    assign mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opd} : '0);
    assign div_rsh  = {acc, sh[WIDTH-1]};
    assign div_diff = div_rsh - {1'b0, opd};

    assign prod   = {acc, sh};
    assign prod_s = neg_p ? -prod : prod;
    // divide by zero leaves an all-ones quotient regardless of signs
    assign quo    = (neg_p && !dz) ? -sh : sh;
    assign rem    = neg_r ? -acc : acc;

    assign res_hi = div_mode ? rem : prod_s[2*WIDTH-1:WIDTH];
    assign res_lo = div_mode ? quo : prod_s[WIDTH-1:0];
    assign idle   = (state == ST_IDLE);
    assign done   = (state == ST_FIX) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            sh       <= '0;
            opd      <= '0;
            div_mode <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_CALC;
                    cnt      <= CW'(WIDTH - 1);
                    acc      <= '0;
                    sh       <= is_div ? mag_a : mag_b;
                    opd      <= is_div ? mag_b : mag_a;
                    div_mode <= is_div;
                    neg_p    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
                    dz       <= (b == '0);
                end
                ST_CALC: begin
                    if (div_mode) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            sh  <= {sh[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_rsh[WIDTH-1:0];
                            sh  <= {sh[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        sh  <= {mul_sum[0], sh[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= ST_FIX;
                end
                ST_FIX:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_md.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative mult/div into HI/LO.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int HALF = WIDTH / 2;

    logic             accept, is_md, md_done, md_idle;
    logic [WIDTH-1:0] alu_out, md_hi, md_lo;

    assign accept   = in_valid && in_ready && !flush;
    assign is_md    = (func[3:2] == 2'b10);
    assign in_ready = md_idle;

    always_comb begin
        alu_out = '0;
        case (func)
            FN_ADD:  alu_out = in1 + in2;
            FN_SUB:  alu_out = in1 - in2;
            FN_OR:   alu_out = in1 | in2;
            FN_AND:  alu_out = in1 & in2;
            FN_XOR:  alu_out = in1 ^ in2;
            FN_XNOR: alu_out = ~(in1 ^ in2);
            FN_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            FN_LUI:  alu_out = {in2[HALF-1:0], {HALF{1'b0}}};
            FN_MFHI: alu_out = hi;
            FN_MFLO: alu_out = lo;
            FN_SLTU: alu_out = {{(WIDTH-1){1'b0}}, in1 < in2};
            default: alu_out = '0;
        endcase
    end

    md_iter #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_md),
        .abort     (flush),
        .is_div    (func[1]),
        .is_signed (~func[0]),
        .a         (in1),
        .b         (in2),
        .idle      (md_idle),
        .done      (md_done),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_md) begin
                result    <= alu_out;
                out_valid <= 1'b1;
            end
            if (md_done) begin
                hi        <= md_hi;
                lo        <= md_lo;
                result    <= '0;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed-vector bench for alu_md at WIDTH=32.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid;
    logic [3:0]  func;
    logic [31:0] in1, in2, result, hi, lo;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .in1(in1), .in2(in2), .flush(flush),
        .result(result), .out_valid(out_valid), .hi(hi), .lo(lo)
    );

    task automatic test_reset;
        rst_n = 0; in_valid = 0; flush = 0; func = 0; in1 = 0; in2 = 0;
        #12;
        tests++; if ({result, hi, lo} !== 96'd0) begin fails++;
            $display("FAIL reset_regs result=%h hi=%h lo=%h expected all 0", result, hi, lo); end
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_single_cycle;
        logic [3:0]  fv[10] = '{4'h6, 4'he, 4'h7, 4'h5, 4'h2, 4'h3, 4'h4, 4'hf, 4'h6, 4'he};
        logic [31:0] av[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h12340000,
                                32'hF0F0F0F0, 32'hAAAA5555, 32'h12345678, 32'h00000005, 32'h00000001};
        logic [31:0] bv[10] = '{32'h00000001, 32'h00000001, 32'h00001234, 32'h00FF00FF, 32'h00005678,
                                32'hFF00FF00, 32'hFFFF0000, 32'h87654321, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ev[10] = '{32'h1, 32'h0, 32'h12340000, 32'hF00FF00F, 32'h12345678,
                                32'hF000F000, 32'h55555555, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 10; i++) begin
            func = fv[i]; in1 = av[i]; in2 = bv[i]; in_valid = 1;
            @(posedge clk); #1 in_valid = 0;
            tests++; if (out_valid !== 1'b1 || result !== ev[i]) begin fails++;
                $display("FAIL single_%0d func=%h got valid=%b result=%h expected 1/%h",
                         i, fv[i], out_valid, result, ev[i]); end
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b0 || result !== ev[i]) begin fails++;
                $display("FAIL single_hold_%0d got valid=%b result=%h expected 0/%h",
                         i, out_valid, result, ev[i]); end
        end
    endtask

    task automatic test_back_to_back;
        func = 4'h0; in1 = 32'h7FFFFFFF; in2 = 32'h1; in_valid = 1;
        @(posedge clk); #1;
        tests++; if (result !== 32'h80000000 || out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++;
            $display("FAIL b2b_add result=%h valid=%b ready=%b expected 80000000/1/1",
                     result, out_valid, in_ready); end
        func = 4'h1; in1 = 32'h0; in2 = 32'h1;
        @(posedge clk); #1 in_valid = 0;
        tests++; if (result !== 32'hFFFFFFFF || out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++;
            $display("FAIL b2b_sub result=%h valid=%b ready=%b expected ffffffff/1/1",
                     result, out_valid, in_ready); end
    endtask

    task automatic test_idle_flush;
        logic [31:0] prev;
        prev = result;
        func = 4'h0; in1 = 32'h1; in2 = 32'h1; in_valid = 1; flush = 1;
        @(posedge clk); #1 in_valid = 0; flush = 0;
        tests++; if (out_valid !== 1'b0 || result !== prev) begin fails++;
            $display("FAIL idle_flush valid=%b result=%h expected 0/%h", out_valid, result, prev); end
    endtask

    task automatic test_md(input string nm, input logic [3:0] f, input logic [31:0] a, b, eh, el);
        int n, busy;
        bit seen;
        func = f; in1 = a; in2 = b; in_valid = 1;
        @(posedge clk); #1 in_valid = 0; in1 = ~a; in2 = ~b;
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL %s_accept_valid got %b expected 0", nm, out_valid); end
        n = 0; busy = 0; seen = 0;
        while (!seen && n < 40) begin
            if (in_ready === 1'b0) busy++;
            @(posedge clk); #1;
            n++;
            seen = (out_valid === 1'b1);
        end
        tests++; if (!seen || n != 33 || busy != 33) begin fails++;
            $display("FAIL %s_latency done=%0b edges=%0d busy=%0d expected 1/33/33", nm, seen, n, busy); end
        tests++; if (hi !== eh || lo !== el || result !== 32'h0) begin fails++;
            $display("FAIL %s_hilo hi=%h lo=%h result=%h expected %h/%h/0", nm, hi, lo, result, eh, el); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL %s_pulse valid=%b ready=%b expected 0/1", nm, out_valid, in_ready); end
    endtask

    task automatic test_flush_calc;
        logic [31:0] oh, ol;
        int pulses;
        oh = hi; ol = lo;
        func = 4'h8; in1 = 32'd7; in2 = 32'd9; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (10) @(posedge clk);
        #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL flush_ready ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) pulses++; end
        tests++; if (pulses != 0 || hi !== oh || lo !== ol) begin fails++;
            $display("FAIL flush_hilo pulses=%0d hi=%h lo=%h expected 0/%h/%h", pulses, hi, lo, oh, ol); end
        func = 4'hd; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        tests++; if (result !== ol || out_valid !== 1'b1) begin fails++;
            $display("FAIL flush_mflo result=%h valid=%b expected %h/1", result, out_valid, ol); end
    endtask

    task automatic test_reset_mid_div;
        func = 4'hb; in1 = 32'd100; in2 = 32'd7; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1;
        tests++; if ({hi, lo, result} !== 96'd0 || out_valid !== 1'b0) begin fails++;
            $display("FAIL rst_mid_regs hi=%h lo=%h result=%h valid=%b expected 0", hi, lo, result, out_valid); end
        #1 rst_n = 1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL rst_mid_ready ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        func = 4'hc; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        tests++; if (result !== 32'h0 || out_valid !== 1'b1) begin fails++;
            $display("FAIL rst_mid_mfhi result=%h valid=%b expected 0/1", result, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_idle_flush();
        test_md("mult",   4'h8, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        test_md("multu",  4'h9, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
        test_md("div",    4'ha, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_md("divu",   4'hb, 32'd100,      32'd7, 32'h00000002, 32'h0000000E);
        test_md("divu0",  4'hb, 32'd5,        32'd0, 32'h00000005, 32'hFFFFFFFF);
        test_md("divmn",  4'ha, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        test_md("div0s",  4'ha, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        test_flush_calc();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Keeps the eight single-cycle logic/arithmetic ops, fixes set-less-than semantics, and adds SLTU.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, a valid/ready handshake, and a flush input.
- Sits in the EX stage. The hazard unit stalls on in_ready=0 and flushes on branch mispredict or exception.

Parameters:
- WIDTH, 32, datapath width; even, >=8.
- HALF, WIDTH/2, upper-immediate shift amount for LUI (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- func  in  4  operation code (see Behaviour).
- in1  in  WIDTH  operand A / dividend / multiplicand.
- in2  in  WIDTH  operand B / divisor / multiplier.
- flush  in  1  abort in-flight mult/div; drop the offered op.
- result  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse: result valid, or mult/div completed.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, async): state=IDLE, result=0, out_valid=0, hi=0, lo=0, counter=0, all internal operand/accumulator regs 0. in_ready=1 once reset is deasserted.
- Accept: rising edge with in_valid && in_ready && !flush. flush has priority over acceptance.
- Func codes:
  - 0000 ADD
  - 0001 SUB
  - 0010 OR
  - 0011 AND
  - 0100 XOR
  - 0101 XNOR
  - 0110 SLT (signed, result 1/0)
  - 0111 LUI = {in2[HALF-1:0], HALF zeros}
  - 1000 MULT
  - 1001 MULTU
  - 1010 DIV
  - 1011 DIVU
  - 1100 MFHI
  - 1101 MFLO
  - 1110 SLTU
  - 1111 reserved, result 0.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Single-cycle ops (incl. MFHI/MFLO/reserved):
  - result registered on the accepting edge; out_valid=1 for the following cycle.
  - Back-to-back accepts allowed every cycle.
  - MFHI/MFLO return the HI/LO value present at the accepting edge.
- Mult/div (1000-1011):
  - Accepting edge: state IDLE->CALC, counter=WIDTH-1, operand magnitudes latched (signed ops take absolute values), sign flags saved. out_valid=0 and result unchanged on this edge.
  - CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). counter decrements; at counter==0, go to FIX.
  - FIX: apply signs. Product negated if signs differ. Quotient negated if signs differ; remainder takes the dividend's sign.
  - FIX->IDLE edge: hi/lo written (mult: hi=upper, lo=lower product; div: lo=quotient, hi=remainder), out_valid pulses, result=0.
  - Total: acceptance edge to hi/lo update = WIDTH+1 edges. in_ready=0 throughout CALC and FIX.
- Divide by zero: runs full latency; lo=all ones, hi=in1 (dividend unmodified), for both signed and unsigned.
- Signed most-negative / -1: lo=most-negative value, hi=0 (wrap, no trap).
- flush during CALC/FIX: state->IDLE next edge; hi/lo untouched; no out_valid.
- flush in IDLE: offered op ignored; result holds; out_valid=0.
- Reset mid-operation: async return to reset values; hi/lo cleared.
- in1/in2/func are don't-care when not accepted. Operands are not required to be stable during CALC.

Decomposition:
- Shared package alu_pkg:
  - func code localparams (FN_ADD..FN_SLTU).
  - state encoding (IDLE, CALC, FIX).
  - WIDTH default constant.
- One sub-module md_iter: the iterative multiply/divide datapath, containing accumulator, shift regs, counter, and sign fix-up. Its interface is start/abort/done, with top-level alu_md owning the handshake, single-cycle ops, and HI/LO.

Test Plan:
- WIDTH=32: SLT in1=FFFFFFFF in2=00000001 -> result=1, out_valid next cycle. SLTU same operands -> 0. LUI in2=00001234 -> 12340000.
- Back-to-back: ADD 7FFFFFFF+1, then SUB 0-1, on consecutive cycles -> results 80000000, FFFFFFFF on consecutive cycles; in_ready stays 1.
- MULT in1=FFFFFFFD (-3), in2=5 -> in_ready low 33 cycles; hi=FFFFFFFF, lo=FFFFFFF1 exactly 33 edges after accept. MULTU same operands -> hi=00000004, lo=FFFFFFF1.
- DIV in1=FFFFFFF9 (-7), in2=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002. DIVU 5/0 -> lo=FFFFFFFF, hi=00000005.
- MULT with flush asserted at cycle 10 of CALC -> in_ready=1 next cycle, hi/lo keep prior values, no out_valid; a following MFLO returns the old lo.
- Assert rst_n=0 mid-DIV (asynchronously, between edges) -> hi=lo=result=0 and in_ready=1 immediately after release; then MFHI -> 0.
